useq_mailbox: RTL
=================

Name: useq_mailbox

Overview:
Parametrised bidirectional mailbox between an external host and a useq-class microsequencer core. It generalises the core's single host FIFO into two independent FIFOs, host-to-core (H2C) and core-to-host (C2H), each with parametrised width and depth. Each FIFO provides correct full/empty flags, simultaneous push/pop, and sticky overflow/underflow error flags. A thresholded, maskable interrupt request goes to the core. Sits beside the core and outside its fetch/execute path, so host traffic never stalls instruction execution.

Parameters:
DATA_W, 8, width of every FIFO entry
H2C_DEPTH, 4, H2C entries; power of two, >= 2
C2H_DEPTH, 4, C2H entries; power of two, >= 2
H2C_THRESH, 1, H2C occupancy at or above which core_irq asserts; range 1..H2C_DEPTH

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
host_push  in  1  push host_wdata into H2C
host_wdata  in  DATA_W  H2C write data
host_full  out  1  H2C full
host_pop  in  1  pop C2H head
host_rdata  out  DATA_W  registered C2H read data
host_rvalid  out  1  host_rdata updated this cycle
host_empty  out  1  C2H empty
core_push  in  1  push core_wdata into C2H
core_wdata  in  DATA_W  C2H write data
core_full  out  1  C2H full
core_pop  in  1  pop H2C head
core_rdata  out  DATA_W  registered H2C read data
core_rvalid  out  1  core_rdata updated this cycle
core_empty  out  1  H2C empty
h2c_count  out  $clog2(H2C_DEPTH)+1  H2C occupancy
c2h_count  out  $clog2(C2H_DEPTH)+1  C2H occupancy
irq_en  in  1  core interrupt enable
core_irq  out  1  level interrupt to core
err_clr  in  1  clear sticky error flags
err  out  4  sticky errors: [0] H2C overflow, [1] H2C underflow, [2] C2H overflow, [3] C2H underflow

Behaviour:
- Reset, asynchronous: all pointers, counts, rdata, rvalid and err go to 0; both empty flags go to 1; full flags and core_irq go to 0. Storage contents are don't-care. Reset mid-transfer discards all queued data.
- Each FIFO is circular. Pointers are $clog2(DEPTH) bits and wrap naturally. The count is one bit wider than the pointers, so a full FIFO is distinguishable from an empty one.
- full = (count == DEPTH); empty = (count == 0). Both are combinational from registered count.
- Push accepted when not full: write at wptr, then wptr+1, count+1.
- Push while full (and no pop the same cycle): data dropped; overflow bit set.
- Pop accepted when not empty: rdata <= mem[rptr] on the next edge, rvalid=1 for exactly that cycle, then rptr+1, count-1.
- Pop while empty: rdata holds its value; rvalid=0; underflow bit set.
- Simultaneous push+pop when 0 < count < DEPTH: both performed; count unchanged.
- Simultaneous push+pop when full: both performed (pop frees the slot); no overflow.
- Simultaneous push+pop when empty: push only; pop ignored; underflow set. No write-through bypass: data becomes poppable one cycle after push.
- Read latency is 1 cycle from pop to rdata/rvalid.
- core_irq = irq_en & (h2c_count >= H2C_THRESH). It is registered, so it lags the count by 1 cycle and drops 1 cycle after the count falls below threshold.
- err bits are sticky until err_clr. If err_clr coincides with a new error the same cycle, the new error wins and the bit stays 1.
- The H2C and C2H paths are fully independent; no cross-path arbitration.

Decomposition:
- Package useq_pkg: error-bit index constants (ERR_H2C_OVF=0, ERR_H2C_UDF=1, ERR_C2H_OVF=2, ERR_C2H_UDF=3) and a count-width helper function.
- Sub-module useq_fifo (params DATA_W, DEPTH; ports push/wdata/pop/rdata/rvalid/full/empty/count/ovf/udf). It is instantiated twice; the top adds irq and sticky-error logic.

Test Plan:
- Reset then idle -> host_empty=core_empty=1, counts=0, err=0, core_irq=0.
- host pushes 0x11,0x22,0x33,0x44 (depth 4) -> h2c_count=4, host_full=1. A fifth push of 0x55 -> err[0]=1, count stays 4. core pops 4 times -> core_rdata 0x11..0x44, each 1 cycle after its pop.
- Fill C2H to full, then host_pop with core_push 0xAA in the same cycle -> count stays 4, no err[2]. After three more pops, the fourth yields 0xAA.
- core_pop with H2C empty -> err[1]=1, core_rvalid=0. Assert err_clr -> err[1]=0. Repeat the pop with err_clr held -> err[1] stays 1.
- H2C_THRESH=2, irq_en=1: one push -> core_irq=0; second push -> core_irq=1 one cycle later; one pop -> core_irq=0 one cycle later. With irq_en=0 -> core_irq stays 0.
- Wrap: 10 interleaved push/pop pairs with data 0..9 through a depth-4 FIFO -> output order 0..9, no errors. Assert rst_n low mid-stream -> counts=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared constants and helpers for the useq host/core mailbox.
package useq_pkg;

    localparam int ERR_H2C_OVF = 0;
    localparam int ERR_H2C_UDF = 1;
    localparam int ERR_C2H_OVF = 2;
    localparam int ERR_C2H_UDF = 3;
    localparam int ERR_W       = 4;

    // Occupancy needs one bit more than the pointer so full and empty differ.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/useq_mailbox_if.sv
// Host/core mailbox signal bundle; master drives requests, slave is the mailbox.
interface useq_mailbox_if
    import useq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int H2C_DEPTH = 4,
    parameter int C2H_DEPTH = 4
);
    logic                          host_push;
    logic [DATA_W-1:0]             host_wdata;
    logic                          host_full;
    logic                          host_pop;
    logic [DATA_W-1:0]             host_rdata;
    logic                          host_rvalid;
    logic                          host_empty;
    logic                          core_push;
    logic [DATA_W-1:0]             core_wdata;
    logic                          core_full;
    logic                          core_pop;
    logic [DATA_W-1:0]             core_rdata;
    logic                          core_rvalid;
    logic                          core_empty;
    logic [cnt_w(H2C_DEPTH)-1:0]   h2c_count;
    logic [cnt_w(C2H_DEPTH)-1:0]   c2h_count;
    logic                          irq_en;
    logic                          core_irq;
    logic                          err_clr;
    logic [ERR_W-1:0]              err;

    modport master (
        output host_push, host_wdata, host_pop, core_push, core_wdata,
               core_pop, irq_en, err_clr,
        input  host_full, host_rdata, host_rvalid, host_empty, core_full,
               core_rdata, core_rvalid, core_empty, h2c_count, c2h_count,
               core_irq, err
    );

    modport slave (
        input  host_push, host_wdata, host_pop, core_push, core_wdata,
               core_pop, irq_en, err_clr,
        output host_full, host_rdata, host_rvalid, host_empty, core_full,
               core_rdata, core_rvalid, core_empty, h2c_count, c2h_count,
               core_irq, err
    );

endinterface

// File: rtl/useq_fifo.sv
// Circular FIFO with registered read port and one-cycle overflow/underflow strobes.
module useq_fifo
    import useq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      rvalid_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      ovf_o,
    output logic                      udf_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              push_ok_s, pop_ok_s;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == {CNT_W{1'b0}});
    assign count_o  = count_q;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

    // A pop on a full FIFO frees the slot, so a same-cycle push is still taken.
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);
    assign ovf_o     = push_i & ~push_ok_s;
    assign udf_o     = pop_i & ~pop_ok_s;

    // Next-state for pointers, occupancy and the read register.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = pop_ok_s;
        if (push_ok_s) begin
            wptr_d = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok_s) begin
            rptr_d  = rptr_q + PTR_W'(1);
            rdata_d = mem_q[rptr_q];
        end else begin
            rptr_d  = rptr_q;
            rdata_d = rdata_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= {PTR_W{1'b0}};
            rptr_q   <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage array; contents are meaningless after reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/useq_mailbox.sv
// Bidirectional host/core mailbox: two independent FIFOs, sticky errors, threshold irq.
module useq_mailbox
    import useq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int H2C_DEPTH  = 4,
    parameter int C2H_DEPTH  = 4,
    parameter int H2C_THRESH = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    useq_mailbox_if.slave  mbx
);
    localparam int H2C_CNT_W = cnt_w(H2C_DEPTH);

    logic             h2c_ovf_s, h2c_udf_s, c2h_ovf_s, c2h_udf_s;
    logic [ERR_W-1:0] new_err_s;
    logic [ERR_W-1:0] err_q, err_d;
    logic             irq_q, irq_d;

    useq_fifo #(.DATA_W(DATA_W), .DEPTH(H2C_DEPTH)) u_h2c (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (mbx.host_push),
        .wdata_i  (mbx.host_wdata),
        .pop_i    (mbx.core_pop),
        .rdata_o  (mbx.core_rdata),
        .rvalid_o (mbx.core_rvalid),
        .full_o   (mbx.host_full),
        .empty_o  (mbx.core_empty),
        .count_o  (mbx.h2c_count),
        .ovf_o    (h2c_ovf_s),
        .udf_o    (h2c_udf_s)
    );

    useq_fifo #(.DATA_W(DATA_W), .DEPTH(C2H_DEPTH)) u_c2h (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (mbx.core_push),
        .wdata_i  (mbx.core_wdata),
        .pop_i    (mbx.host_pop),
        .rdata_o  (mbx.host_rdata),
        .rvalid_o (mbx.host_rvalid),
        .full_o   (mbx.core_full),
        .empty_o  (mbx.host_empty),
        .count_o  (mbx.c2h_count),
        .ovf_o    (c2h_ovf_s),
        .udf_o    (c2h_udf_s)
    );

    // Sticky errors: a clear coinciding with a fresh error leaves that bit set.
    always_comb begin
        new_err_s              = {ERR_W{1'b0}};
        new_err_s[ERR_H2C_OVF] = h2c_ovf_s;
        new_err_s[ERR_H2C_UDF] = h2c_udf_s;
        new_err_s[ERR_C2H_OVF] = c2h_ovf_s;
        new_err_s[ERR_C2H_UDF] = c2h_udf_s;
        if (mbx.err_clr) begin
            err_d = new_err_s;
        end else begin
            err_d = err_q | new_err_s;
        end
        irq_d = mbx.irq_en & (mbx.h2c_count >= H2C_CNT_W'(H2C_THRESH));
    end

    // Registered error flags and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= {ERR_W{1'b0}};
            irq_q <= 1'b0;
        end else begin
            err_q <= err_d;
            irq_q <= irq_d;
        end
    end

    assign mbx.err      = err_q;
    assign mbx.core_irq = irq_q;

endmodule
